// File: rtl/issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : issue_pkg
//  Description : Shared types for the issue queue controller: PC type, queue
//                entry layout, bubble encoding and the fetch FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package issue_pkg;

    typedef logic [12:0] pc_t;

    typedef struct packed {
        pc_t         pc;
        logic [31:0] inst;
    } entry_t;

    // Instruction word presented on an invalid issue slot (pipeline bubble)
    localparam logic [31:0] NOP_INST = 32'd0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } fsm_t;

endpackage
`default_nettype wire

// File: rtl/issue_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : issue_fifo_mem
//  Description : Queue storage. Two combinational read ports (entry at the
//                read pointer and the one after it) and one pair-write port
//                that writes one or two consecutive entries at the write
//                pointer. No reset: contents are don't-care until written.
//  Ports       : clk        - clock
//                i_wr_en    - write enable
//                i_wr_two   - also write i_wr_e1 at i_wr_ptr+1
//                i_wr_ptr   - first write index
//                i_wr_e0/1  - entries to write
//                i_rd_ptr   - first read index
//                o_rd_e0/1  - entries at i_rd_ptr and i_rd_ptr+1
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_fifo_mem
    import issue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic          i_wr_two,
    input  logic [AW-1:0] i_wr_ptr,
    input  entry_t        i_wr_e0,
    input  entry_t        i_wr_e1,
    input  logic [AW-1:0] i_rd_ptr,
    output entry_t        o_rd_e0,
    output entry_t        o_rd_e1
);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] w_wr_ptr1;
    logic [AW-1:0] w_rd_ptr1;

    // Indices wrap naturally because DEPTH is a power of two
    assign w_wr_ptr1 = i_wr_ptr + AW'(1);
    assign w_rd_ptr1 = i_rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_ptr] <= i_wr_e0;
            if (i_wr_two) begin
                mem_q[w_wr_ptr1] <= i_wr_e1;
            end
        end
    end

    assign o_rd_e0 = mem_q[i_rd_ptr];
    assign o_rd_e1 = mem_q[w_rd_ptr1];

endmodule
`default_nettype wire

// File: rtl/issue_queue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : issue_queue_ctrl
//  Description : Dual-issue front-end scheduler. Fetches instruction pairs,
//                buffers them in an in-order queue, presents the two oldest
//                entries to decode and retires 0..2 per cycle. Owns the fetch
//                PC and handles branch redirects.
//  Ports       : CLK, NRST          - clock, async active-low reset
//                imem_req/addr      - pair fetch request (addr 8-byte aligned)
//                imem_data0/1       - fetch response, one cycle after request
//                iss_valid          - slot valid bits (bit1 implies bit0)
//                iss_pc0/1,inst0/1  - oldest / second-oldest entries
//                iss_take, stall    - entries consumed by decode, stall
//                redirect(_pc)      - flush and refetch from redirect_pc
//                q_count            - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_queue_ctrl
    import issue_pkg::*;
#(
    parameter pc_t RESET_PC = 13'd0,
    parameter int  DEPTH    = 8
) (
    input  logic        CLK,
    input  logic        NRST,
    output logic        imem_req,
    output logic [12:0] imem_addr,
    input  logic [31:0] imem_data0,
    input  logic [31:0] imem_data1,
    output logic [1:0]  iss_valid,
    output logic [12:0] iss_pc0,
    output logic [12:0] iss_pc1,
    output logic [31:0] iss_inst0,
    output logic [31:0] iss_inst1,
    input  logic [1:0]  iss_take,
    input  logic        stall,
    input  logic        redirect,
    input  logic [12:0] redirect_pc,
    output logic [3:0]  q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 2;

    // Registered state
    fsm_t          state_q,     state_d;
    logic [AW-1:0] head_q,      head_d;
    logic [AW-1:0] tail_q,      tail_d;
    logic [CW-1:0] count_q,     count_d;
    pc_t           fetch_pc_q,  fetch_pc_d;   // next address to request
    pc_t           req_pc_q,    req_pc_d;     // PC of the in-flight request
    logic          req_half_q,  req_half_d;   // in-flight request was misaligned
    logic          inflight_q,  inflight_d;
    logic          epoch_q,     epoch_d;
    logic          req_epoch_q, req_epoch_d;

    // Combinational
    logic [1:0]    avail;
    logic [1:0]    eff_take;
    logic [SW-1:0] space_need;
    logic          space_ok;
    logic          resp_ok;
    logic [1:0]    enq_n;
    entry_t        wr_e0, wr_e1, rd_e0, rd_e1;

    issue_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (CLK),
        .i_wr_en  (resp_ok),
        .i_wr_two (~req_half_q),
        .i_wr_ptr (tail_q),
        .i_wr_e0  (wr_e0),
        .i_wr_e1  (wr_e1),
        .i_rd_ptr (head_q),
        .o_rd_e0  (rd_e0),
        .o_rd_e1  (rd_e1)
    );

    // ------------------------------------------------------------------
    // Issue slots: driven only from registered queue state
    // ------------------------------------------------------------------
    always_comb begin
        iss_valid = 2'b11;
        if (count_q == '0) begin
            iss_valid = 2'b00;
        end else if (count_q == CW'(1)) begin
            iss_valid = 2'b01;
        end
        iss_pc0   = iss_valid[0] ? rd_e0.pc   : 13'd0;
        iss_inst0 = iss_valid[0] ? rd_e0.inst : NOP_INST;
        iss_pc1   = iss_valid[1] ? rd_e1.pc   : 13'd0;
        iss_inst1 = iss_valid[1] ? rd_e1.inst : NOP_INST;
    end

    assign q_count   = 4'(count_q);
    assign imem_addr = {fetch_pc_q[12:3], 3'b000};

    // ------------------------------------------------------------------
    // Retire and space accounting
    // ------------------------------------------------------------------
    always_comb begin
        avail      = (iss_valid == 2'b11) ? 2'd2 : iss_valid;
        eff_take   = stall ? 2'd0 : ((iss_take > avail) ? avail : iss_take);
        // A reserved response counts as two entries even if it turns out to
        // be a misaligned single, which keeps the queue from overflowing.
        space_need = SW'(count_q) - SW'(eff_take) + (inflight_q ? SW'(4) : SW'(2));
        space_ok   = (space_need <= SW'(DEPTH));
    end

    // ------------------------------------------------------------------
    // Fetch response: dropped if a redirect happened since it was issued
    // or is happening now
    // ------------------------------------------------------------------
    always_comb begin
        resp_ok    = inflight_q && (req_epoch_q == epoch_q) && !redirect;
        enq_n      = resp_ok ? (req_half_q ? 2'd1 : 2'd2) : 2'd0;
        wr_e0.pc   = req_pc_q;
        wr_e0.inst = req_half_q ? imem_data1 : imem_data0;
        wr_e1.pc   = req_pc_q + 13'd4;
        wr_e1.inst = imem_data1;
    end

    // ------------------------------------------------------------------
    // FSM next state / request
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!redirect) begin
                    if (space_ok) begin
                        imem_req = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (redirect || space_ok) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        if (redirect) begin
            state_d = RUN;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        inflight_d  = imem_req;
        req_pc_d    = imem_req ? fetch_pc_q : req_pc_q;
        req_half_d  = imem_req ? fetch_pc_q[2] : req_half_q;
        req_epoch_d = imem_req ? epoch_q : req_epoch_q;
        epoch_d     = epoch_q ^ redirect;
        tail_d      = tail_q + AW'(enq_n);
        fetch_pc_d  = fetch_pc_q;
        head_d      = head_q + AW'(eff_take);
        count_d     = count_q + CW'(enq_n) - CW'(eff_take);
        if (imem_req) begin
            // A misaligned target fetches only its upper half
            fetch_pc_d = fetch_pc_q + (fetch_pc_q[2] ? 13'd4 : 13'd8);
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            head_d     = tail_q;
            count_d    = '0;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q     <= BOOT;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            req_half_q  <= 1'b0;
            inflight_q  <= 1'b0;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            req_half_q  <= req_half_d;
            inflight_q  <= inflight_d;
            epoch_q     <= epoch_d;
            req_epoch_q <= req_epoch_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_queue_ctrl
//  Description : Self-checking bench for issue_queue_ctrl. A queue-based
//                reference model predicts every output each cycle; a few
//                literal expectations pin the model to known scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_queue_ctrl;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        NRST;
    logic        imem_req;
    logic [12:0] imem_addr;
    logic [31:0] imem_data0, imem_data1;
    logic [1:0]  iss_valid;
    logic [12:0] iss_pc0, iss_pc1;
    logic [31:0] iss_inst0, iss_inst1;
    logic [1:0]  iss_take;
    logic        stall, redirect;
    logic [12:0] redirect_pc;
    logic [3:0]  q_count;

    issue_queue_ctrl #(.RESET_PC(13'd0), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .NRST(NRST),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_data0(imem_data0), .imem_data1(imem_data1),
        .iss_valid(iss_valid), .iss_pc0(iss_pc0), .iss_pc1(iss_pc1),
        .iss_inst0(iss_inst0), .iss_inst1(iss_inst1),
        .iss_take(iss_take), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .q_count(q_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct { logic [12:0] pc; logic [31:0] inst; } ment_t;
    ment_t       mq[$];
    int          m_phase;      // 0 = boot cycle, 1 = fetching, 2 = waiting for space
    logic [12:0] m_fpc, m_ipc;
    bit          m_half, m_infl;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_avail();
        return (mq.size() > 2) ? 2 : mq.size();
    endfunction

    function automatic int m_eff();
        if (stall) return 0;
        return (int'(iss_take) > m_avail()) ? m_avail() : int'(iss_take);
    endfunction

    function automatic bit m_space();
        return (mq.size() - m_eff() + 2 + (m_infl ? 2 : 0)) <= DEPTH;
    endfunction

    function automatic bit m_req();
        return (m_phase == 1) && !redirect && m_space();
    endfunction

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_fpc   = 13'd0;
        m_ipc   = 13'd0;
        m_half  = 1'b0;
        m_infl  = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 3 units later, well before the next rising edge.
    task automatic drive(input bit s, input int tk, input bit rd, input logic [12:0] rpc);
        int t;
        t = tk;
        if (!s && t > m_avail()) t = m_avail();
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        iss_take    = 2'(t);
        imem_data0  = $urandom;
        imem_data1  = $urandom;
        #3;
    endtask

    task automatic compare_model();
        logic [1:0]  v;
        logic [12:0] p0, p1;
        logic [31:0] i0, i1;
        v  = (mq.size() == 0) ? 2'b00 : (mq.size() == 1) ? 2'b01 : 2'b11;
        p0 = 13'd0; p1 = 13'd0; i0 = 32'd0; i1 = 32'd0;
        if (mq.size() > 0) begin p0 = mq[0].pc; i0 = mq[0].inst; end
        if (mq.size() > 1) begin p1 = mq[1].pc; i1 = mq[1].inst; end
        chk("iss_valid", 32'(iss_valid), 32'(v));
        chk("iss_pc0",   32'(iss_pc0),   32'(p0));
        chk("iss_pc1",   32'(iss_pc1),   32'(p1));
        chk("iss_inst0", iss_inst0,      i0);
        chk("iss_inst1", iss_inst1,      i1);
        chk("q_count",   32'(q_count),   32'(mq.size()));
        chk("imem_req",  32'(imem_req),  32'(m_req()));
        chk("imem_addr", 32'(imem_addr), 32'({m_fpc[12:3], 3'b000}));
    endtask

    task automatic advance();
        ment_t e;
        bit    req, sp;
        int    eff;
        req = m_req();
        sp  = m_space();
        eff = m_eff();
        if (redirect) begin
            mq.delete();
            m_fpc   = redirect_pc;
            m_phase = 1;
            m_infl  = 1'b0;
        end else begin
            for (int i = 0; i < eff; i++) void'(mq.pop_front());
            if (m_infl) begin
                if (m_half) begin
                    e.pc = m_ipc; e.inst = imem_data1; mq.push_back(e);
                end else begin
                    e.pc = m_ipc;         e.inst = imem_data0; mq.push_back(e);
                    e.pc = m_ipc + 13'd4; e.inst = imem_data1; mq.push_back(e);
                end
            end
            if (m_phase == 0)                 m_phase = 1;
            else if (m_phase == 1 && !req)    m_phase = 2;
            else if (m_phase == 2 && sp)      m_phase = 1;
            m_infl = req;
            if (req) begin
                m_ipc  = m_fpc;
                m_half = m_fpc[2];
                m_fpc  = m_fpc + (m_fpc[2] ? 13'd4 : 13'd8);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc(input bit s, input int tk, input bit rd, input logic [12:0] rpc);
        drive(s, tk, rd, rpc);
        compare_model();
        advance();
    endtask

    // Called at rising edge + 1 with NRST low; releases reset and walks the
    // first cycles with iss_take = 2.
    task automatic boot_seq();
        NRST = 1'b1;
        model_reset();
        for (int c = 0; c < 8; c++) begin
            drive(0, 2, 0, 13'd0);
            compare_model();
            case (c)
                0: chk("boot_no_req", 32'(imem_req), 32'd0);
                1: begin
                    chk("first_req",      32'(imem_req),  32'd1);
                    chk("first_req_addr", 32'(imem_addr), 32'd0);
                end
                2: chk("c2_empty", 32'(iss_valid), 32'd0);
                3: begin
                    chk("c3_valid", 32'(iss_valid), 32'd3);
                    chk("c3_pc0",   32'(iss_pc0),   32'd0);
                    chk("c3_pc1",   32'(iss_pc1),   32'd4);
                end
                4: begin
                    chk("c4_pc0", 32'(iss_pc0), 32'd8);
                    chk("c4_pc1", 32'(iss_pc1), 32'd12);
                end
                7: chk("c7_pc0", 32'(iss_pc0), 32'd32);
                default: ;
            endcase
            advance();
        end
    endtask

    initial begin
        bit          found;
        logic [12:0] held_pc;
        NRST = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 13'd0;
        iss_take = 2'd0; imem_data0 = 32'd0; imem_data1 = 32'd0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        #3;
        compare_model();                       // state while reset is held
        @(posedge CLK);
        #1;

        // Scenario: boot with iss_take = 2
        boot_seq();

        // Scenario: one entry retired per cycle
        repeat (20) cyc(0, 1, 0, 13'd0);

        // Scenario: stall with six entries queued
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mq.size() == 6) found = 1'b1;
            else cyc(0, (mq.size() < 6) ? 0 : 1, 0, 13'd0);
        end
        chk("reach_count6", 32'(found), 32'd1);
        held_pc = (mq.size() > 0) ? mq[0].pc : 13'd0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, 0, 13'd0);
            compare_model();
            chk("stall_hold_pc0", 32'(iss_pc0), 32'(held_pc));
            chk("stall_count_le_depth", 32'(q_count <= 4'd8), 32'd1);
            advance();
        end

        // Scenario: redirect while a fetch is in flight
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_infl) found = 1'b1;
            else cyc(0, 1, 0, 13'd0);
        end
        chk("inflight_before_redirect", 32'(found), 32'd1);
        drive(0, 1, 1, 13'h104); compare_model();
        chk("redir_no_req", 32'(imem_req), 32'd0);
        advance();
        drive(0, 0, 0, 13'd0); compare_model();
        chk("redir_req",      32'(imem_req),  32'd1);
        chk("redir_req_addr", 32'(imem_addr), 32'h100);
        advance();
        drive(0, 0, 0, 13'd0); compare_model();
        chk("redir_stale_dropped", 32'(iss_valid), 32'd0);
        advance();
        drive(0, 1, 0, 13'd0); compare_model();
        chk("redir_first_valid", 32'(iss_valid), 32'd1);
        chk("redir_first_pc",    32'(iss_pc0),   32'h104);
        advance();
        drive(0, 0, 0, 13'd0); compare_model();
        chk("redir_next_valid", 32'(iss_valid), 32'd3);
        chk("redir_next_pc0",   32'(iss_pc0),   32'h108);
        chk("redir_next_pc1",   32'(iss_pc1),   32'h10C);
        advance();

        // Scenario: redirect together with stall
        repeat (4) cyc(0, 0, 0, 13'd0);
        cyc(1, 2, 1, 13'h040);
        drive(0, 0, 0, 13'd0); compare_model();
        chk("flush_under_stall", 32'(q_count), 32'd0);
        advance();

        // Scenario: reset pulsed while a response is due
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_infl) found = 1'b1;
            else cyc(0, 2, 0, 13'd0);
        end
        chk("inflight_before_reset", 32'(found), 32'd1);
        NRST = 1'b0;
        #1;
        chk("rst_imem_req",  32'(imem_req),  32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_iss_pc0",   32'(iss_pc0),   32'd0);
        chk("rst_iss_pc1",   32'(iss_pc1),   32'd0);
        chk("rst_iss_inst0", iss_inst0,      32'd0);
        chk("rst_iss_inst1", iss_inst1,      32'd0);
        chk("rst_q_count",   32'(q_count),   32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        boot_seq();

        // Scenario: randomized traffic
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 2),
                $urandom_range(0, 24) == 0, 13'($urandom) & 13'h1FFC);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
